snake_body_streamer: RTL and testbench

Upstream stage of the game renderer. Holds the snake segment list, advances it one grid cell per move tick (with optional growth), checks for wall and self collision, and once per frame streams every segment coordinate on a serial bus. The renderer rebuilds its body array from that bus. Playfield is 124 × 81 blocks (x 0..123, y 0..80).

---
 rtl/snake_body_streamer_if.sv | 39 +++
 rtl/snake_body_streamer.sv | 230 +++++++++++++++++++++++
 tb/tb_snake_body_streamer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_streamer_if.sv
// snake_body_streamer_if
// Bundles the move/frame request inputs and the snake state / body stream
// outputs of snake_body_streamer.
//   master : game logic / testbench side (drives requests, observes state)
//   slave  : snake_body_streamer side
// Signals:
//   move_tick, direction[1:0], grow, frame_start      requests
//   snake_head_x/y[6:0]                               head block coordinate
//   snake_body_x/y[6:0], en_snake_body                serial segment stream
//   snake_length[LEN_W-1:0], wall_hit, self_collision, busy   status
interface snake_body_streamer_if #(
    parameter int LEN_W = 6
);
    logic             move_tick;
    logic [1:0]       direction;
    logic             grow;
    logic             frame_start;
    logic [6:0]       snake_head_x;
    logic [6:0]       snake_head_y;
    logic [6:0]       snake_body_x;
    logic [6:0]       snake_body_y;
    logic             en_snake_body;
    logic [LEN_W-1:0] snake_length;
    logic             wall_hit;
    logic             self_collision;
    logic             busy;

    modport master (
        output move_tick, direction, grow, frame_start,
        input  snake_head_x, snake_head_y, snake_body_x, snake_body_y,
               en_snake_body, snake_length, wall_hit, self_collision, busy
    );

    modport slave (
        input  move_tick, direction, grow, frame_start,
        output snake_head_x, snake_head_y, snake_body_x, snake_body_y,
               en_snake_body, snake_length, wall_hit, self_collision, busy
    );
endinterface

// File: rtl/snake_body_streamer.sv
// snake_body_streamer
// Holds the snake segment list on a 124x81 block playfield, advances it one
// cell per move request (optionally growing), checks wall and self collision,
// and streams every segment coordinate once per frame request.
// Ports:
//   clock_25  25 MHz system clock
//   reset     asynchronous, active-low
//   bus       snake_body_streamer_if.slave (requests in, state/stream out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting; services pending frame first, then pending move
// S_MOVE   | one cycle: wall check, shift segments, optional growth
// S_CHECK  | compares head against seg[1..length-1], one per cycle
// S_STREAM | drives seg[0..length-1] on the body bus, one per cycle
module snake_body_streamer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic                  clock_25,
    input  logic                  reset,
    snake_body_streamer_if.slave  bus
);
    localparam int               IDX_W     = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_CHECK, S_STREAM} state_t;

    state_t           state_q, state_d;
    logic [6:0]       seg_x_q [MAX_LEN];
    logic [6:0]       seg_y_q [MAX_LEN];
    logic [6:0]       seg_x_d [MAX_LEN];
    logic [6:0]       seg_y_d [MAX_LEN];
    logic [LEN_W-1:0] length_q, length_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [1:0]       dir_q, dir_d;
    logic             move_pend_q, move_pend_d;
    logic             frame_pend_q, frame_pend_d;
    logic [1:0]       mv_dir_q, mv_dir_d;
    logic             mv_grow_q, mv_grow_d;
    logic             wall_hit_q, wall_hit_d;
    logic             self_col_q, self_col_d;
    logic [6:0]       body_x_q, body_x_d;
    logic [6:0]       body_y_q, body_y_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;

    logic             frozen;
    logic [1:0]       eff_dir;
    logic [6:0]       new_x, new_y;
    logic             off_grid;
    logic [IDX_W-1:0] sel;

    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        idx_d        = idx_q;
        dir_d        = dir_q;
        move_pend_d  = move_pend_q;
        frame_pend_d = frame_pend_q;
        mv_dir_d     = mv_dir_q;
        mv_grow_d    = mv_grow_q;
        wall_hit_d   = wall_hit_q;
        self_col_d   = self_col_q;
        body_x_d     = body_x_q;
        body_y_d     = body_y_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end

        frozen = wall_hit_q | self_col_q;
        sel    = idx_q[IDX_W-1:0];

        // Reversal codes differ only in bit 1 (00/10, 01/11).
        eff_dir  = ((mv_dir_q ^ dir_q) == 2'b10) ? dir_q : mv_dir_q;
        new_x    = seg_x_q[0];
        new_y    = seg_y_q[0];
        off_grid = 1'b0;
        case (eff_dir)
            2'b00: begin
                off_grid = (seg_y_q[0] == 7'd0);
                new_y    = seg_y_q[0] - 7'd1;
            end
            2'b01: begin
                off_grid = (seg_x_q[0] == 7'd123);
                new_x    = seg_x_q[0] + 7'd1;
            end
            2'b10: begin
                off_grid = (seg_y_q[0] == 7'd80);
                new_y    = seg_y_q[0] + 7'd1;
            end
            default: begin
                off_grid = (seg_x_q[0] == 7'd0);
                new_x    = seg_x_q[0] - 7'd1;
            end
        endcase

        // Request capture: every request lands in its pending latch first;
        // IDLE then services the latches in the same cycle.
        if (bus.frame_start) begin
            frame_pend_d = 1'b1;
        end
        if (bus.move_tick && !move_pend_q && !frozen) begin
            move_pend_d = 1'b1;
            mv_dir_d    = bus.direction;
            mv_grow_d   = bus.grow;
        end
        if (frozen) begin
            move_pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_pend_d) begin
                    state_d      = S_STREAM;
                    frame_pend_d = 1'b0;
                    body_x_d     = seg_x_q[0];
                    body_y_d     = seg_y_q[0];
                    idx_d        = ONE;
                end else if (move_pend_d) begin
                    state_d     = S_MOVE;
                    move_pend_d = 1'b0;
                end
            end
            S_MOVE: begin
                dir_d = eff_dir;
                if (off_grid) begin
                    wall_hit_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = new_x;
                    seg_y_d[0] = new_y;
                    // The shift already copies the old tail into seg[length].
                    if (mv_grow_q && (length_q < MAX_LEN_L)) begin
                        length_d = length_q + ONE;
                    end
                    idx_d   = ONE;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((seg_x_q[0] == seg_x_q[sel]) && (seg_y_q[0] == seg_y_q[sel])) begin
                    self_col_d = 1'b1;
                end
                if (idx_q == (length_q - ONE)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            S_STREAM: begin
                if (idx_q == length_q) begin
                    state_d = S_IDLE;
                end else begin
                    body_x_d = seg_x_q[sel];
                    body_y_d = seg_y_q[sel];
                    idx_d    = idx_q + ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d   = (state_d == S_STREAM);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
            seg_x_q[0]   <= 7'd62;
            seg_x_q[1]   <= 7'd61;
            seg_x_q[2]   <= 7'd60;
            seg_y_q[0]   <= 7'd40;
            seg_y_q[1]   <= 7'd40;
            seg_y_q[2]   <= 7'd40;
            length_q     <= LEN_W'(3);
            idx_q        <= '0;
            dir_q        <= 2'b01;
            move_pend_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            mv_dir_q     <= 2'b01;
            mv_grow_q    <= 1'b0;
            wall_hit_q   <= 1'b0;
            self_col_q   <= 1'b0;
            body_x_q     <= '0;
            body_y_q     <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
            length_q     <= length_d;
            idx_q        <= idx_d;
            dir_q        <= dir_d;
            move_pend_q  <= move_pend_d;
            frame_pend_q <= frame_pend_d;
            mv_dir_q     <= mv_dir_d;
            mv_grow_q    <= mv_grow_d;
            wall_hit_q   <= wall_hit_d;
            self_col_q   <= self_col_d;
            body_x_q     <= body_x_d;
            body_y_q     <= body_y_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.snake_head_x   = seg_x_q[0];
    assign bus.snake_head_y   = seg_y_q[0];
    assign bus.snake_body_x   = body_x_q;
    assign bus.snake_body_y   = body_y_q;
    assign bus.en_snake_body  = en_q;
    assign bus.snake_length   = length_q;
    assign bus.wall_hit       = wall_hit_q;
    assign bus.self_collision = self_col_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_snake_body_streamer.sv
// tb_snake_body_streamer
// Directed, table-driven bench for snake_body_streamer. A queue of expected
// segment coordinates is rebuilt from the hand-computed head positions and
// used to check every streamed beat.
module tb_snake_body_streamer;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic clock_25;
    logic reset;

    snake_body_streamer_if #(.LEN_W(LEN_W)) bus ();

    snake_body_streamer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (bus)
    );

    initial begin
        clock_25 = 1'b0;
        forever #20 clock_25 = ~clock_25;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef enum int {OP_MOVE, OP_FRAME, OP_RESET} op_e;
    typedef struct {
        op_e        op;
        logic [1:0] dir;
        logic       grow;
        int         hx;
        int         hy;
        int         len;
        logic       wall;
        logic       selfc;
    } vec_t;

    int         tests;
    int         fails;
    logic [13:0] model[$];
    bit         model_frozen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_init();
        model.delete();
        model.push_back({7'd62, 7'd40});
        model.push_back({7'd61, 7'd40});
        model.push_back({7'd60, 7'd40});
        model_frozen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock_25);
        reset = 1'b1;
        model_init();
    endtask

    task automatic wait_idle(output int n, output int self_at);
        n       = 0;
        self_at = -1;
        while (bus.busy && n < 200) begin
            @(negedge clock_25);
            n++;
            if (bus.self_collision && self_at < 0) self_at = n;
        end
    endtask

    // Called at the falling edge right after the frame request was sampled.
    task automatic stream_check(input string name);
        for (int k = 0; k < model.size(); k++) begin
            chk($sformatf("%s_beat%0d", name, k),
                32'({bus.en_snake_body, bus.snake_body_x, bus.snake_body_y}),
                32'({1'b1, model[k]}));
            @(negedge clock_25);
        end
        chk($sformatf("%s_en_end", name), 32'(bus.en_snake_body), 32'd0);
    endtask

    task automatic do_frame(input string name);
        @(negedge clock_25);
        bus.frame_start = 1'b1;
        @(negedge clock_25);
        bus.frame_start = 1'b0;
        stream_check(name);
        @(negedge clock_25);
    endtask

    task automatic do_move(input string name, input logic [1:0] d, input logic g,
                           input int hx, input int hy, input int len,
                           input logic w, input logic s);
        int  n;
        int  self_at;
        bit  was_frozen;
        bit  grew;
        was_frozen = model_frozen;
        @(negedge clock_25);
        bus.move_tick = 1'b1;
        bus.direction = d;
        bus.grow      = g;
        @(negedge clock_25);
        bus.move_tick = 1'b0;
        wait_idle(n, self_at);
        chk($sformatf("%s_idle_timeout", name), 32'(bus.busy), 32'd0);
        chk($sformatf("%s_busy_time", name), 32'(n <= len + 1), 32'd1);
        chk($sformatf("%s_head_x", name), 32'(bus.snake_head_x), 32'(hx));
        chk($sformatf("%s_head_y", name), 32'(bus.snake_head_y), 32'(hy));
        chk($sformatf("%s_length", name), 32'(bus.snake_length), 32'(len));
        chk($sformatf("%s_wall", name), 32'(bus.wall_hit), 32'(w));
        chk($sformatf("%s_self", name), 32'(bus.self_collision), 32'(s));
        if (s && !was_frozen) begin
            chk($sformatf("%s_self_latency", name), 32'(self_at >= 0 && self_at <= len), 32'd1);
        end
        if (!was_frozen && !w) begin
            grew = g && (model.size() < MAX_LEN);
            model.push_front({hx[6:0], hy[6:0]});
            if (!grew) void'(model.pop_back());
        end
        model_frozen = w | s;
    endtask

    vec_t vecs[15];

    initial begin
        int n;
        int self_at;
        tests = 0;
        fails = 0;
        reset           = 1'b0;
        bus.move_tick   = 1'b0;
        bus.direction   = 2'b01;
        bus.grow        = 1'b0;
        bus.frame_start = 1'b0;

        vecs[0]  = '{OP_MOVE,  2'b01, 1'b0, 63, 40, 3, 1'b0, 1'b0};
        vecs[1]  = '{OP_FRAME, 2'b00, 1'b0,  0,  0, 0, 1'b0, 1'b0};
        vecs[2]  = '{OP_MOVE,  2'b11, 1'b0, 64, 40, 3, 1'b0, 1'b0};
        vecs[3]  = '{OP_MOVE,  2'b01, 1'b1, 65, 40, 4, 1'b0, 1'b0};
        vecs[4]  = '{OP_FRAME, 2'b00, 1'b0,  0,  0, 0, 1'b0, 1'b0};
        vecs[5]  = '{OP_MOVE,  2'b00, 1'b0, 65, 39, 4, 1'b0, 1'b0};
        vecs[6]  = '{OP_MOVE,  2'b10, 1'b0, 65, 38, 4, 1'b0, 1'b0};
        vecs[7]  = '{OP_RESET, 2'b00, 1'b0, 62, 40, 3, 1'b0, 1'b0};
        vecs[8]  = '{OP_MOVE,  2'b01, 1'b1, 63, 40, 4, 1'b0, 1'b0};
        vecs[9]  = '{OP_MOVE,  2'b01, 1'b1, 64, 40, 5, 1'b0, 1'b0};
        vecs[10] = '{OP_MOVE,  2'b00, 1'b0, 64, 39, 5, 1'b0, 1'b0};
        vecs[11] = '{OP_MOVE,  2'b11, 1'b0, 63, 39, 5, 1'b0, 1'b0};
        vecs[12] = '{OP_MOVE,  2'b10, 1'b0, 63, 40, 5, 1'b0, 1'b1};
        vecs[13] = '{OP_FRAME, 2'b00, 1'b0,  0,  0, 0, 1'b0, 1'b0};
        vecs[14] = '{OP_MOVE,  2'b01, 1'b0, 63, 40, 5, 1'b0, 1'b1};

        // Reset state
        @(negedge clock_25);
        do_reset();
        chk("rst_head_x", 32'(bus.snake_head_x), 32'd62);
        chk("rst_head_y", 32'(bus.snake_head_y), 32'd40);
        chk("rst_length", 32'(bus.snake_length), 32'd3);
        chk("rst_en", 32'(bus.en_snake_body), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wall", 32'(bus.wall_hit), 32'd0);
        chk("rst_self", 32'(bus.self_collision), 32'd0);
        chk("rst_body", 32'({bus.snake_body_x, bus.snake_body_y}), 32'd0);
        do_frame("rst_frame");

        // Table-driven moves / frames / resets
        for (int i = 0; i < 15; i++) begin
            case (vecs[i].op)
                OP_MOVE: do_move($sformatf("v%0d", i), vecs[i].dir, vecs[i].grow,
                                 vecs[i].hx, vecs[i].hy, vecs[i].len,
                                 vecs[i].wall, vecs[i].selfc);
                OP_FRAME: do_frame($sformatf("v%0d_frame", i));
                default: begin
                    do_reset();
                    chk($sformatf("v%0d_head", i),
                        32'({bus.snake_head_x, bus.snake_head_y}),
                        32'({vecs[i].hx[6:0], vecs[i].hy[6:0]}));
                    chk($sformatf("v%0d_length", i), 32'(bus.snake_length), 32'(vecs[i].len));
                    chk($sformatf("v%0d_flags", i),
                        32'({bus.wall_hit, bus.self_collision}), 32'd0);
                end
            endcase
        end

        // Grow to saturation, run into the right wall, then stay frozen
        do_reset();
        for (int i = 0; i < 30; i++) begin
            do_move($sformatf("grow%0d", i), 2'b01, 1'b1, 63 + i, 40,
                    (4 + i > MAX_LEN) ? MAX_LEN : 4 + i, 1'b0, 1'b0);
        end
        do_frame("full_frame");
        for (int i = 0; i < 31; i++) begin
            do_move($sformatf("run%0d", i), 2'b01, 1'b0, 93 + i, 40, MAX_LEN, 1'b0, 1'b0);
        end
        do_move("wall_move", 2'b01, 1'b0, 123, 40, MAX_LEN, 1'b1, 1'b0);
        do_move("frozen_up", 2'b00, 1'b0, 123, 40, MAX_LEN, 1'b1, 1'b0);
        do_frame("frozen_frame");

        // Simultaneous move and frame: stream old positions, then move
        do_reset();
        @(negedge clock_25);
        bus.move_tick   = 1'b1;
        bus.direction   = 2'b01;
        bus.grow        = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clock_25);
        bus.move_tick   = 1'b0;
        bus.frame_start = 1'b0;
        stream_check("simul");
        @(negedge clock_25);
        wait_idle(n, self_at);
        chk("simul_idle_timeout", 32'(bus.busy), 32'd0);
        chk("simul_head", 32'({bus.snake_head_x, bus.snake_head_y}), 32'({7'd63, 7'd40}));
        chk("simul_length", 32'(bus.snake_length), 32'd3);
        model.push_front({7'd63, 7'd40});
        void'(model.pop_back());
        do_frame("simul_after");

        // Reset in the middle of a stream
        do_move("pre_rst", 2'b01, 1'b1, 64, 40, 4, 1'b0, 1'b0);
        @(negedge clock_25);
        bus.frame_start = 1'b1;
        @(negedge clock_25);
        bus.frame_start = 1'b0;
        @(negedge clock_25);
        chk("mid_en_before", 32'(bus.en_snake_body), 32'd1);
        #5;
        reset = 1'b0;
        #1;
        chk("mid_rst_en", 32'(bus.en_snake_body), 32'd0);
        @(negedge clock_25);
        chk("mid_rst_length", 32'(bus.snake_length), 32'd3);
        chk("mid_rst_head", 32'({bus.snake_head_x, bus.snake_head_y}), 32'({7'd62, 7'd40}));
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        model_init();
        do_frame("post_rst_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
